fetch_queue_unit: RTL and testbench

Parametrised instruction-fetch front end: owns the fetch PC register, issues single-outstanding requests to instruction memory, and buffers returned words in a DEPTH-entry prefetch queue feeding decode through a valid/ready handshake. Redirects from execute/exception logic flush the queue and discard in-flight responses. Redirect priority is eret > exception > jr > jmp > taken branch > sequential.

---
 rtl/fetch_queue_unit.sv | 133 +++++++++++++
 tb/tb_fetch_queue_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: fetch PC, single-outstanding imem requests,
// DEPTH-entry prefetch queue toward decode, and redirect/flush handling.
module fetch_queue_unit #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0080
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  output logic          if_valid,
  input  logic          if_ready,
  output logic [31:0]   if_instr,
  output logic [AW-1:0] if_pc,
  input  logic [AW-1:0] br_pc,
  input  logic          eret,
  input  logic          exception,
  input  logic          jr,
  input  logic          jmp,
  input  logic          branch,
  input  logic          z,
  input  logic [AW-1:0] epc,
  input  logic [AW-1:0] ra,
  input  logic [25:0]   target,
  input  logic [15:0]   imm
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] fpc;
  logic [AW-1:0] req_pc;
  logic          outstanding;
  logic          discard;

  logic [AW-1:0] q_pc    [DEPTH];
  logic [31:0]   q_instr [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          redirect_c;
  logic [AW-1:0] redirect_pc_c;
  logic [AW-1:0] raw_target_c;
  logic [AW-1:0] jmp_target_c;
  logic [AW-1:0] br_target_c;
  logic [31:0]   br_offset_c;
  logic          fire_c;
  logic          accept_c;
  logic          push_c;
  logic          pop_c;

  // Redirect detection and target selection, highest priority first
  always_comb begin
    redirect_c    = eret | exception | jr | jmp | (branch & ~z);
    br_offset_c   = {{14{imm[15]}}, imm, 2'b00};
    br_target_c   = br_pc + AW'(32'd4) + AW'(br_offset_c);
    jmp_target_c  = (br_pc & AW'(32'hF000_0000)) | AW'({target, 2'b00});
    raw_target_c  = br_target_c;
    if (eret)           raw_target_c = epc;
    else if (exception) raw_target_c = AW'(EXC_VECTOR);
    else if (jr)        raw_target_c = ra;
    else if (jmp)       raw_target_c = jmp_target_c;
    redirect_pc_c = raw_target_c & ~AW'(32'd3);
  end

  // Handshake qualifiers: issue, response acceptance, queue push/pop
  always_comb begin
    imem_req = ~rst & ~redirect_c & ~outstanding & ~discard & (count < CW'(DEPTH));
    fire_c   = imem_req & imem_gnt;
    accept_c = imem_rvalid & outstanding;
    push_c   = accept_c & ~discard & ~redirect_c;
    pop_c    = if_valid & if_ready & ~redirect_c;
  end

  // Queue head presentation; zeroed when empty
  always_comb begin
    imem_addr = fpc;
    if_valid  = (count != '0);
    if_instr  = if_valid ? q_instr[head] : 32'd0;
    if_pc     = if_valid ? q_pc[head] : '0;
  end

  // Fetch PC, in-flight tracking and stale-response discard flag
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc         <= AW'(RESET_VECTOR);
      req_pc      <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else begin
      if (redirect_c)  fpc <= redirect_pc_c;
      else if (fire_c) fpc <= fpc + AW'(32'd4);

      if (fire_c) begin
        req_pc      <= fpc;
        outstanding <= 1'b1;
      end else if (accept_c) begin
        outstanding <= 1'b0;
      end

      if (accept_c)                       discard <= 1'b0;
      else if (redirect_c && outstanding) discard <= 1'b1;
    end
  end

  // Queue pointers and occupancy; redirect flushes everything
  always_ff @(posedge clk) begin
    if (rst || redirect_c) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_c) tail <= tail + PW'(1);
      if (pop_c)  head <= head + PW'(1);
      count <= count + CW'(push_c) - CW'(pop_c);
    end
  end

  // Queue storage, written on push only
  always_ff @(posedge clk) begin
    if (push_c) begin
      q_pc[tail]    <= req_pc;
      q_instr[tail] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit with an imem responder model.
module tb_fetch_queue_unit;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] br_pc;
  logic        eret, exception, jr, jmp, branch, z;
  logic [31:0] epc, ra;
  logic [25:0] target;
  logic [15:0] imm;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] pop_pc[$];
  logic [31:0] pop_ins[$];
  logic [31:0] fire_addrs[$];
  bit          last_fire, last_rv;
  logic [31:0] last_addr;
  int          mcount;
  bit          pend;
  int          cd;
  logic [31:0] paddr;
  int          lat_cfg;
  bit          rand_lat, rand_gnt, rand_ready;
  logic [31:0] salt;

  fetch_queue_unit #(.AW(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .br_pc(br_pc), .eret(eret), .exception(exception), .jr(jr), .jmp(jmp),
    .branch(branch), .z(z), .epc(epc), .ra(ra), .target(target), .imm(imm)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'hC0DE} ^ salt;
  endfunction

  // Architectural redirect rule: priority chain, word-aligned result
  function automatic logic [31:0] ref_target(input bit e, input bit x, input bit j,
      input bit m, input bit b, input bit zz, input logic [31:0] ep,
      input logic [31:0] r, input logic [31:0] bp, input logic [25:0] t,
      input logic [15:0] im, output bit act);
    logic [31:0] res;
    int s;
    act = e || x || j || m || (b && !zz);
    s = int'($signed(im));
    if (e)      res = ep;
    else if (x) res = 32'h8000_0080;
    else if (j) res = r;
    else if (m) res = {bp[31:28], t, 2'b00};
    else        res = bp + 32'd4 + 32'(s * 4);
    return res & ~32'd3;
  endfunction

  // One clock: sample handshakes, advance, then update responder and drivers
  task automatic tick();
    bit pop;
    #1;
    last_fire = (imem_req === 1'b1) && (imem_gnt === 1'b1);
    last_rv   = (imem_rvalid === 1'b1);
    last_addr = imem_addr;
    pop       = (if_valid === 1'b1) && (if_ready === 1'b1);
    if (last_fire) fire_addrs.push_back(imem_addr);
    if (pop) begin
      pop_pc.push_back(if_pc);
      pop_ins.push_back(if_instr);
    end
    if (last_rv) mcount++;
    if (pop)     mcount--;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    if (last_fire) begin
      pend  = 1'b1;
      paddr = last_addr;
      cd    = rand_lat ? int'($urandom_range(1, 3)) : lat_cfg;
    end
    if (pend) begin
      cd--;
      if (cd == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(paddr);
        pend        = 1'b0;
      end
    end
    if (rand_gnt)   imem_gnt = 1'($urandom_range(0, 1));
    if (rand_ready) if_ready = 1'($urandom_range(0, 1));
    #1;
  endtask

  task automatic clear_logs();
    pop_pc.delete();
    pop_ins.delete();
    fire_addrs.delete();
  endtask

  task automatic clear_redirect();
    eret = 0; exception = 0; jr = 0; jmp = 0; branch = 0; z = 0;
    br_pc = '0; epc = '0; ra = '0; target = '0; imm = '0;
  endtask

  // Long enough reset for any in-flight response to drain
  task automatic do_reset();
    rst = 1'b1;
    clear_redirect();
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic apply_redirect(input bit e, input bit x, input bit j, input bit m,
      input bit b, input bit zz, input logic [31:0] ep, input logic [31:0] r,
      input logic [31:0] bp, input logic [25:0] t, input logic [15:0] im);
    eret = e; exception = x; jr = j; jmp = m; branch = b; z = zz;
    epc = ep; ra = r; br_pc = bp; target = t; imm = im;
    tick();
    clear_redirect();
  endtask

  task automatic test_reset();
    rst = 1'b1; if_ready = 1'b1; imem_gnt = 1'b1; lat_cfg = 1;
    for (int i = 0; i < 3; i++) tick();
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
    n_tests++; if (if_instr !== 32'd0) begin n_fail++; $display("FAIL reset_instr got=%h exp=0", if_instr); end
    n_tests++; if (if_pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", if_pc); end
    rst = 1'b0;
    clear_logs();
    #1;
    n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req got=%b exp=1", imem_req); end
    n_tests++; if (imem_addr !== 32'd0) begin n_fail++; $display("FAIL first_addr got=%h exp=0", imem_addr); end
  endtask

  task automatic test_stream();
    tick();
    n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early got=%b exp=0", if_valid); end
    tick();
    n_tests++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid got=%b exp=1", if_valid); end
    n_tests++; if (if_pc !== 32'd0) begin n_fail++; $display("FAIL lat_pc got=%h exp=0", if_pc); end
    n_tests++; if (if_instr !== mem_word(32'd0)) begin n_fail++; $display("FAIL lat_instr got=%h exp=%h", if_instr, mem_word(32'd0)); end
    for (int i = 0; i < 22; i++) tick();
    n_tests++; if (fire_addrs.size() != 12) begin n_fail++; $display("FAIL stream_rate got=%0d exp=12", fire_addrs.size()); end
    for (int i = 0; i < 8 && i < fire_addrs.size(); i++) begin
      n_tests++; if (fire_addrs[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL stream_addr[%0d] got=%h exp=%h", i, fire_addrs[i], 32'(4 * i)); end
    end
    for (int i = 0; i < pop_pc.size(); i++) begin
      n_tests++;
      if (pop_pc[i] !== 32'(4 * i) || pop_ins[i] !== mem_word(32'(4 * i))) begin
        n_fail++; $display("FAIL stream_pop[%0d] got=%h/%h exp=%h/%h", i, pop_pc[i], pop_ins[i], 32'(4 * i), mem_word(32'(4 * i)));
      end
    end
  endtask

  task automatic test_full();
    lat_cfg = 1; imem_gnt = 1'b1; if_ready = 1'b1;
    do_reset();
    if_ready = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    n_tests++; if (fire_addrs.size() != DEPTH) begin n_fail++; $display("FAIL full_count got=%0d exp=%0d", fire_addrs.size(), DEPTH); end
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL full_req got=%b exp=0", imem_req); end
    n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'd0) begin n_fail++; $display("FAIL full_head got=%b/%h exp=1/0", if_valid, if_pc); end
    clear_logs();
    if_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (i >= pop_pc.size()) begin
        n_fail++; $display("FAIL drain_pop[%0d] got=none exp=%h", i, 32'(4 * i));
      end else if (pop_pc[i] !== 32'(4 * i) || pop_ins[i] !== mem_word(32'(4 * i))) begin
        n_fail++; $display("FAIL drain_pop[%0d] got=%h/%h exp=%h", i, pop_pc[i], pop_ins[i], 32'(4 * i));
      end
    end
    n_tests++;
    if (fire_addrs.size() == 0 || fire_addrs[0] !== 32'h10) begin
      n_fail++; $display("FAIL resume_addr got=%h exp=00000010", fire_addrs.size() ? fire_addrs[0] : 32'hFFFF_FFFF);
    end
  endtask

  task automatic test_branch();
    logic [31:0] exp_addr;
    clear_logs();
    apply_redirect(0, 0, 0, 0, 1, 0, '0, '0, 32'h100, '0, 16'hFFFE);
    n_tests++; if (imem_addr !== 32'h0FC) begin n_fail++; $display("FAIL br_addr got=%h exp=000000fc", imem_addr); end
    n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL br_flush got=%b exp=0", if_valid); end
    for (int i = 0; i < 10; i++) tick();
    n_tests++;
    if (fire_addrs.size() == 0 || fire_addrs[0] !== 32'h0FC) begin
      n_fail++; $display("FAIL br_fetch got=%h exp=000000fc", fire_addrs.size() ? fire_addrs[0] : 32'hFFFF_FFFF);
    end
    n_tests++;
    if (pop_pc.size() == 0 || pop_pc[0] !== 32'h0FC || pop_ins[0] !== mem_word(32'h0FC)) begin
      n_fail++; $display("FAIL br_pop got=%h exp=000000fc", pop_pc.size() ? pop_pc[0] : 32'hFFFF_FFFF);
    end
    apply_redirect(0, 0, 0, 0, 1, 1, '0, '0, 32'h100, '0, 16'hFFFE);
    exp_addr = last_fire ? last_addr + 32'd4 : last_addr;
    n_tests++; if (imem_addr !== exp_addr) begin n_fail++; $display("FAIL br_not_taken got=%h exp=%h", imem_addr, exp_addr); end
  endtask

  task automatic test_priority();
    bit act;
    logic [31:0] exp_addr, e_ep, e_r, e_bp;
    logic [25:0] e_t;
    logic [15:0] e_im;
    bit ce, cx, cj, cm, cb, cz;
    apply_redirect(1, 1, 1, 0, 0, 0, 32'h400, 32'h2000, '0, '0, '0);
    n_tests++; if (imem_addr !== 32'h400) begin n_fail++; $display("FAIL prio_eret got=%h exp=00000400", imem_addr); end
    apply_redirect(0, 1, 1, 1, 1, 0, 32'h400, 32'h2000, 32'h100, 26'h40, 16'h1);
    n_tests++; if (imem_addr !== 32'h8000_0080) begin n_fail++; $display("FAIL prio_exc got=%h exp=80000080", imem_addr); end
    apply_redirect(0, 0, 0, 1, 0, 0, '0, '0, 32'h1000_0000, 26'h40, '0);
    n_tests++; if (imem_addr !== 32'h1000_0100) begin n_fail++; $display("FAIL prio_jmp got=%h exp=10000100", imem_addr); end
    apply_redirect(0, 0, 1, 1, 1, 0, '0, 32'h2003, 32'h1000_0000, 26'h40, '0);
    n_tests++; if (imem_addr !== 32'h2000) begin n_fail++; $display("FAIL prio_jr got=%h exp=00002000", imem_addr); end
    for (int i = 0; i < 24; i++) begin
      ce = ($urandom_range(0, 5) == 0); cx = ($urandom_range(0, 5) == 0);
      cj = ($urandom_range(0, 4) == 0); cm = ($urandom_range(0, 3) == 0);
      cb = 1'($urandom_range(0, 1));    cz = 1'($urandom_range(0, 1));
      e_ep = $urandom; e_r = $urandom; e_bp = $urandom;
      e_t = 26'($urandom); e_im = 16'($urandom);
      exp_addr = ref_target(ce, cx, cj, cm, cb, cz, e_ep, e_r, e_bp, e_t, e_im, act);
      apply_redirect(ce, cx, cj, cm, cb, cz, e_ep, e_r, e_bp, e_t, e_im);
      if (!act) exp_addr = last_fire ? last_addr + 32'd4 : last_addr;
      n_tests++; if (imem_addr !== exp_addr) begin n_fail++; $display("FAIL rand_redirect[%0d] got=%h exp=%h", i, imem_addr, exp_addr); end
      tick();
    end
  endtask

  task automatic test_redirect_outstanding();
    int rv_at, fire_at;
    bit got;
    lat_cfg = 3; imem_gnt = 1'b1; if_ready = 1'b1;
    do_reset();
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin tick(); got = last_fire; end
    n_tests++; if (!got) begin n_fail++; $display("FAIL ro_wait_fire got=none exp=request"); end
    clear_logs();
    apply_redirect(0, 0, 1, 0, 0, 0, '0, 32'h3000, '0, '0, '0);
    n_tests++; if (imem_addr !== 32'h3000) begin n_fail++; $display("FAIL ro_addr got=%h exp=00003000", imem_addr); end
    rv_at = -1; fire_at = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_rv && rv_at < 0) rv_at = i;
      if (last_fire && fire_at < 0) fire_at = i;
    end
    n_tests++;
    if (rv_at < 0 || fire_at != rv_at + 1) begin
      n_fail++; $display("FAIL ro_reissue got=rv@%0d req@%0d exp=req one cycle after rv", rv_at, fire_at);
    end
    n_tests++;
    if (pop_pc.size() == 0 || pop_pc[0] !== 32'h3000 || pop_ins[0] !== mem_word(32'h3000)) begin
      n_fail++; $display("FAIL ro_first_pop got=%h exp=00003000", pop_pc.size() ? pop_pc[0] : 32'hFFFF_FFFF);
    end
    n_tests++;
    if (fire_addrs.size() == 0 || fire_addrs[0] !== 32'h3000) begin
      n_fail++; $display("FAIL ro_fetch got=%h exp=00003000", fire_addrs.size() ? fire_addrs[0] : 32'hFFFF_FFFF);
    end
  endtask

  task automatic test_reset_midflight();
    lat_cfg = 3; imem_gnt = 1'b1; if_ready = 1'b1;
    do_reset();
    if_ready = 1'b0;
    for (int i = 0; i < 60 && fire_addrs.size() < DEPTH; i++) tick();
    n_tests++; if (fire_addrs.size() != DEPTH) begin n_fail++; $display("FAIL mf_fill got=%0d exp=%0d", fire_addrs.size(), DEPTH); end
    rst = 1'b1;
    #1;
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL mf_req_in_rst got=%b exp=0", imem_req); end
    tick();
    n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL mf_valid got=%b exp=0", if_valid); end
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL mf_req got=%b exp=0", imem_req); end
    tick();
    rst = 1'b0; if_ready = 1'b1;
    clear_logs();
    #1;
    n_tests++; if (imem_addr !== 32'd0 || imem_req !== 1'b1) begin n_fail++; $display("FAIL mf_restart got=%h/%b exp=00000000/1", imem_addr, imem_req); end
    for (int i = 0; i < 20; i++) tick();
    n_tests++;
    if (pop_pc.size() < 2 || pop_pc[0] !== 32'd0 || pop_ins[0] !== mem_word(32'd0) || pop_pc[1] !== 32'd4) begin
      n_fail++; $display("FAIL mf_pops got=%h/%h exp=00000000/%h", pop_pc.size() ? pop_pc[0] : 32'hFFFF_FFFF,
                         pop_ins.size() ? pop_ins[0] : 32'hFFFF_FFFF, mem_word(32'd0));
    end
  endtask

  task automatic test_random_stream();
    lat_cfg = 1; imem_gnt = 1'b1; if_ready = 1'b1;
    do_reset();
    mcount = 0;
    rand_lat = 1; rand_gnt = 1; rand_ready = 1;
    for (int c = 0; c < 400; c++) begin
      tick();
      n_tests++;
      if (if_valid !== (mcount != 0)) begin n_fail++; $display("FAIL rnd_valid@%0d got=%b exp=%b", c, if_valid, mcount != 0); end
      if (mcount >= DEPTH) begin
        n_tests++;
        if (imem_req !== 1'b0 || mcount > DEPTH) begin n_fail++; $display("FAIL rnd_full@%0d got=req%b cnt%0d exp=req0", c, imem_req, mcount); end
      end
    end
    rand_lat = 0; rand_gnt = 0; rand_ready = 0;
    imem_gnt = 1'b1; if_ready = 1'b1;
    n_tests++; if (pop_pc.size() < 20) begin n_fail++; $display("FAIL rnd_progress got=%0d exp=>=20", pop_pc.size()); end
    for (int i = 0; i < pop_pc.size(); i++) begin
      n_tests++;
      if (pop_pc[i] !== 32'(4 * i) || pop_ins[i] !== mem_word(32'(4 * i))) begin
        n_fail++; $display("FAIL rnd_pop[%0d] got=%h/%h exp=%h/%h", i, pop_pc[i], pop_ins[i], 32'(4 * i), mem_word(32'(4 * i)));
      end
    end
  endtask

  initial begin
    salt = $urandom;
    rst = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b1;
    clear_redirect();
    pend = 0; cd = 0; mcount = 0; lat_cfg = 1;
    rand_lat = 0; rand_gnt = 0; rand_ready = 0;
    test_reset();
    test_stream();
    test_full();
    test_branch();
    test_priority();
    test_redirect_outstanding();
    test_reset_midflight();
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
